// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and a simple req/gnt,
// rvalid data memory port.
//
// Ports
//   clk, reset             clock (rising edge) and asynchronous active-high reset
//   valid_i                execute stage presents a memory op this cycle
//   alu_res_i              byte address of the op
//   store_data_i           rs2 value for stores
//   mem_rd_i, mem_wr_i     load / store select (both high = no-op)
//   byte_en_i              access size: 00 byte, 01 half, 1x word
//   zero_extnd_i           loads zero-extend when 1, sign-extend when 0
//   mem_req_o .. mem_strb_o  memory request channel (word-aligned address)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory grant and read response
//   busy_o                 stall to the pipeline
//   rd_valid_o, rd_data_o  load result (rd_data_o holds until next load)
//   done_o                 store complete pulse
//   misaligned_o, err_o    misaligned-op pulse, timeout pulse
// ---------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  byte_en_i,
  input  logic        zero_extnd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_strb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  // Abort fires on the last allowed cycle in REQ/WAIT, so at most
  // TIMEOUT_CYC cycles are spent in either state.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        zext_q, zext_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic        accept;
  logic        op_misaligned;

  function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] fmt_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic [1:0] off,
                                           input logic zext, input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'b00:   return zext ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   return zext ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // Both selects high (or neither) is not an op at all.
  assign accept = (state_q == IDLE) & valid_i & (mem_rd_i ^ mem_wr_i);

  assign op_misaligned = (byte_en_i == 2'b01) ? alu_res_i[0] :
                         byte_en_i[1]         ? (alu_res_i[1:0] != 2'b00) : 1'b0;

  // A misaligned op completes in the accept cycle, so it never stalls.
  assign busy_o = ~reset & ((state_q != IDLE) | (accept & ~op_misaligned));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    off_d      = off_q;
    size_d     = size_q;
    zext_d     = zext_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d   = REQ;
            cnt_d     = 8'd0;
            mem_req_d = 1'b1;
            we_d      = mem_wr_i;
            addr_d    = {alu_res_i[31:2], 2'b00};
            wdata_d   = fmt_wdata(byte_en_i, store_data_i);
            strb_d    = fmt_strb(byte_en_i, alu_res_i[1:0]);
            off_d     = alu_res_i[1:0];
            size_d    = byte_en_i;
            zext_d    = zero_extnd_i;
          end
        end
      end

      REQ: begin
        // rvalid is deliberately not looked at here, even alongside gnt.
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      WAIT: begin
        if (mem_rvalid_i) begin
          state_d    = IDLE;
          cnt_d      = 8'd0;
          rd_data_d  = fmt_load(size_q, off_q, zext_q, mem_rdata_i);
          rd_valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      strb_q     <= 4'h0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      zext_q     <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      off_q      <= off_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_strb_o   = strb_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed + randomized bench for lsu. Two instances share the
// stimulus: dut (default timeout) and dut_t (TIMEOUT_CYC = 4).
// ---------------------------------------------------------------------------
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [31:0] alu_res_i;
  logic [31:0] store_data_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [1:0]  byte_en_i;
  logic        zero_extnd_i;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        mem_req_o, mem_we_o, busy_o, rd_valid_o, done_o, misaligned_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rd_data_o;
  logic [3:0]  mem_strb_o;

  logic        t_mem_req_o, t_mem_we_o, t_busy_o, t_rd_valid_o, t_done_o, t_misaligned_o, t_err_o;
  logic [31:0] t_mem_addr_o, t_mem_wdata_o, t_rd_data_o;
  logic [3:0]  t_mem_strb_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .alu_res_i(alu_res_i),
    .store_data_i(store_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .byte_en_i(byte_en_i), .zero_extnd_i(zero_extnd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .done_o(done_o), .misaligned_o(misaligned_o), .err_o(err_o)
  );

  lsu #(.TIMEOUT_CYC(TO)) dut_t (
    .clk(clk), .reset(reset), .valid_i(valid_i), .alu_res_i(alu_res_i),
    .store_data_i(store_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .byte_en_i(byte_en_i), .zero_extnd_i(zero_extnd_i),
    .mem_req_o(t_mem_req_o), .mem_we_o(t_mem_we_o), .mem_addr_o(t_mem_addr_o),
    .mem_wdata_o(t_mem_wdata_o), .mem_strb_o(t_mem_strb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(t_busy_o), .rd_valid_o(t_rd_valid_o), .rd_data_o(t_rd_data_o),
    .done_o(t_done_o), .misaligned_o(t_misaligned_o), .err_o(t_err_o)
  );

  // ---------------- reference model (arithmetic form of the rules) --------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (nbytes(size) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nbytes(size) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int m;
    m = ((1 << nbytes(size)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic zext, input logic [31:0] rdata);
    logic [31:0] v, mask;
    int n;
    n = nbytes(size);
    v = rdata >> (8 * (addr % 4));
    if (n == 4) return v;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (!zext && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- comparison helpers ------------------------------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_req"}, mem_req_o, 1'b0);
    chk1({tag, "_we"}, mem_we_o, 1'b0);
    chk32({tag, "_addr"}, mem_addr_o, 32'h0);
    chk32({tag, "_wdata"}, mem_wdata_o, 32'h0);
    chk32({tag, "_strb"}, {28'h0, mem_strb_o}, 32'h0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_rdv"}, rd_valid_o, 1'b0);
    chk32({tag, "_rdata"}, rd_data_o, 32'h0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_mis"}, misaligned_o, 1'b0);
    chk1({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic drive_op(input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [1:0] size, input logic zext, input logic wr);
    valid_i = 1'b1; alu_res_i = addr; store_data_i = sdata;
    mem_rd_i = ~wr; mem_wr_i = wr; byte_en_i = size; zero_extnd_i = zext;
  endtask

  // Full transaction on dut, starting at a negedge with dut idle.
  // gdly: REQ cycles before grant; rdly: WAIT cycles before rvalid.
  task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [1:0] size, input logic zext, input logic wr,
                        input int gdly, input int rdly, input logic [31:0] rdata,
                        input logic rv_at_gnt);
    logic mis;
    logic [31:0] exp_rd;
    mis = model_mis(size, addr);
    exp_rd = model_load(size, addr, zext, rdata);
    drive_op(addr, sdata, size, zext, wr);
    #1;
    chk1({tag, "_busy_acc"}, busy_o, ~mis);
    @(negedge clk);
    valid_i = 1'b0;
    if (mis) begin
      chk1({tag, "_mis"}, misaligned_o, 1'b1);
      chk1({tag, "_mis_req"}, mem_req_o, 1'b0);
      chk1({tag, "_mis_busy"}, busy_o, 1'b0);
      @(negedge clk);
      chk1({tag, "_mis_pulse"}, misaligned_o, 1'b0);
      return;
    end
    for (int k = 0; k <= gdly; k++) begin
      chk1({tag, "_req"}, mem_req_o, 1'b1);
      chk1({tag, "_we"}, mem_we_o, wr);
      chk32({tag, "_addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
      chk32({tag, "_wdata"}, mem_wdata_o, model_wdata(size, sdata));
      chk32({tag, "_strb"}, {28'h0, mem_strb_o}, {28'h0, model_strb(size, addr)});
      chk1({tag, "_busy_req"}, busy_o, 1'b1);
      if (k == gdly) begin
        mem_gnt_i = 1'b1;
        if (!wr && rv_at_gnt) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = ~rdata;
        end
      end
      @(negedge clk);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
    end
    if (wr) begin
      chk1({tag, "_done"}, done_o, 1'b1);
      chk1({tag, "_st_busy"}, busy_o, 1'b0);
      chk1({tag, "_st_req"}, mem_req_o, 1'b0);
      chk32({tag, "_rd_hold"}, rd_data_o, last_rd);
      @(negedge clk);
      chk1({tag, "_done_pulse"}, done_o, 1'b0);
    end else begin
      for (int j = 0; j <= rdly; j++) begin
        chk1({tag, "_rdv_early"}, rd_valid_o, 1'b0);
        chk1({tag, "_wait_req"}, mem_req_o, 1'b0);
        chk1({tag, "_busy_wait"}, busy_o, 1'b1);
        if (j == rdly) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rdata;
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
      end
      chk1({tag, "_rdv"}, rd_valid_o, 1'b1);
      chk32({tag, "_rdata"}, rd_data_o, exp_rd);
      chk1({tag, "_ld_busy"}, busy_o, 1'b0);
      last_rd = exp_rd;
      @(negedge clk);
      chk1({tag, "_rdv_pulse"}, rd_valid_o, 1'b0);
      chk32({tag, "_rd_hold"}, rd_data_o, last_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a, d, rd;
    logic [1:0] sz;
    logic ze, w, rvg;

    reset = 1'b1; valid_i = 1'b0; alu_res_i = '0; store_data_i = '0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; byte_en_i = 2'b00; zero_extnd_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk1("reset_t_err", t_err_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Store byte at 0x1003
    run_op("st_byte", 32'h1003, 32'hAABB_CCDD, 2'b00, 1'b0, 1'b1, 0, 0, 32'h0, 1'b0);
    // Load half, sign then zero extended
    run_op("ld_half_sx", 32'h2002, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 32'h8001_1234, 1'b0);
    chk32("ld_half_sx_const", rd_data_o, 32'hFFFF_8001);
    run_op("ld_half_zx", 32'h2002, 32'h0, 2'b01, 1'b1, 1'b0, 0, 0, 32'h8001_1234, 1'b0);
    chk32("ld_half_zx_const", rd_data_o, 32'h0000_8001);
    // Misaligned word
    run_op("mis_word", 32'h0006, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0);
    // rvalid coincident with grant is ignored
    run_op("rv_at_gnt", 32'h3001, 32'h0, 2'b00, 1'b0, 1'b0, 0, 1, 32'h0000_9900, 1'b1);

    // Both selects high: not accepted
    drive_op(32'h4000, 32'h1234_5678, 2'b10, 1'b0, 1'b1);
    mem_rd_i = 1'b1;
    #1;
    chk1("illegal_busy", busy_o, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    chk1("illegal_req", mem_req_o, 1'b0);
    chk1("illegal_mis", misaligned_o, 1'b0);
    @(negedge clk);

    // Randomized ops (delays small enough that dut_t never times out)
    for (int i = 0; i < 40; i++) begin
      a = $urandom; d = $urandom; rd = $urandom;
      sz = 2'($urandom_range(0, 3));
      ze = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      rvg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op("rand", a, d, sz, ze, w, $urandom_range(0, 3), $urandom_range(0, 3), rd, rvg);
    end

    // Grant withheld 5 cycles
    run_op("stall", 32'h5004, 32'hCAFE_F00D, 2'b01, 1'b0, 1'b1, 5, 0, 32'h0, 1'b0);

    // Timeout on dut_t: load granted immediately, no rvalid
    drive_op(32'h6000, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    n = 0;
    while (!t_err_o && n < 20) begin
      chk1("to_busy", t_busy_o, 1'b1);
      @(negedge clk);
      n++;
    end
    chk32("to_cycles", n, TO);
    chk1("to_err", t_err_o, 1'b1);
    chk1("to_idle_busy", t_busy_o, 1'b0);
    chk1("to_req", t_mem_req_o, 1'b0);
    chk1("to_rdv", t_rd_valid_o, 1'b0);
    @(negedge clk);
    chk1("to_err_pulse", t_err_o, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk1("to_late_rv", t_rd_valid_o, 1'b0);
    chk1("to_main_rdv", rd_valid_o, 1'b1);
    chk32("to_main_rdata", rd_data_o, 32'h1357_9BDF);
    @(negedge clk);

    // Reset asserted while in WAIT
    drive_op(32'h7000, 32'h0, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk1("wait_busy", busy_o, 1'b1);
    reset = 1'b1;
    #1;
    chk_zero("rst_wait");
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'h0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk1("post_rst_rv", rd_valid_o, 1'b0);
    chk32("post_rst_rdata", rd_data_o, 32'h0);
    chk1("post_rst_t_rv", t_rd_valid_o, 1'b0);
    @(negedge clk);
    run_op("after_rst", 32'h7001, 32'h0, 2'b00, 1'b0, 1'b0, 0, 0, 32'h0000_8000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
